// File: rtl/uart_rx_fifo_pkg.sv
// uart_rx_fifo_pkg: shared UART receive-path constants.
package uart_rx_fifo_pkg;
    localparam int UART_DATA_W = 8;
    localparam int DEF_DEPTH = 16;
    localparam logic [15:0] DEF_IDLE_CYC = 16'd2000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO with wrap-bit pointers.
module sync_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int W = UART_DATA_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [W-1:0]  din,
    input  logic          rd,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [AW:0]   level,
    output logic          full
);
    localparam logic [AW:0] ONE = 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic do_rd, do_wr;
    assign level = wr_ptr - rd_ptr;
    assign valid = wr_ptr != rd_ptr;
    assign full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_rd = rd & valid;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_wr = wr & (~full | do_rd);
    assign dout = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + ONE;
            if (do_rd) rd_ptr <= rd_ptr + ONE;
        end
    end
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: buffers received UART bytes, flags overflow and
// pulses idle once the line has been quiet for IDLE_CYC cycles after traffic.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW = 4,
    parameter logic [15:0] IDLE_CYC = DEF_IDLE_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rx_done,
    output logic [UART_DATA_W-1:0] m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [AW:0]            level,
    output logic                   full,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic                   idle
);
    localparam logic [15:0] TERM = IDLE_CYC - 16'd1;
    logic rx_done_d, wr_req, pop, drop, armed;
    logic [15:0] cnt;
    assign wr_req = rx_done & ~rx_done_d;
    assign pop = m_valid & m_ready;
    assign drop = wr_req & full & ~pop;
    // a new byte on the terminal cycle restarts the timer instead of pulsing
    assign idle = armed & (cnt == TERM) & ~wr_req;

    sync_fifo #(.W(UART_DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .wr(wr_req),
        .din(rx_data),
        .rd(m_ready),
        .dout(m_data),
        .valid(m_valid),
        .level(level),
        .full(full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_done_d <= 1'b0;
            overflow <= 1'b0;
            armed <= 1'b0;
            cnt <= '0;
        end else begin
            rx_done_d <= rx_done;
            overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
            if (wr_req) begin
                cnt <= '0;
                armed <= 1'b1;
            end else if (armed) begin
                if (cnt == TERM) armed <= 1'b0;
                else cnt <= cnt + 16'd1;
            end
        end
    end
endmodule
